// File: rtl/enc8b10b_pkg.sv
// Shared constants and table functions for the multi-lane 8b/10b encoder.
package enc8b10b_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYM_W  = 10;

  // Running disparity encoding
  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  // Legal control-code bytes
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // True when the byte is one of the twelve legal K codes
  function automatic logic is_legal_k(input logic [7:0] b);
    logic legal;
    legal = 1'b0;
    unique case (b)
      K28_0, K28_1, K28_2, K28_3, K28_4, K28_5, K28_6, K28_7,
      K23_7, K27_7, K29_7, K30_7: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // 5b/6b code (abcdei) used when the current RD is negative
  function automatic logic [5:0] enc5b6b_neg(input logic [4:0] x, input logic k28);
    logic [5:0] c;
    c = 6'b000000;
    if (k28) begin
      c = 6'b001111;
    end else begin
      unique case (x)
        5'd0:  c = 6'b100111;
        5'd1:  c = 6'b011101;
        5'd2:  c = 6'b101101;
        5'd3:  c = 6'b110001;
        5'd4:  c = 6'b110101;
        5'd5:  c = 6'b101001;
        5'd6:  c = 6'b011001;
        5'd7:  c = 6'b111000;
        5'd8:  c = 6'b111001;
        5'd9:  c = 6'b100101;
        5'd10: c = 6'b010101;
        5'd11: c = 6'b110100;
        5'd12: c = 6'b001101;
        5'd13: c = 6'b101100;
        5'd14: c = 6'b011100;
        5'd15: c = 6'b010111;
        5'd16: c = 6'b011011;
        5'd17: c = 6'b100011;
        5'd18: c = 6'b010011;
        5'd19: c = 6'b110010;
        5'd20: c = 6'b001011;
        5'd21: c = 6'b101010;
        5'd22: c = 6'b011010;
        5'd23: c = 6'b111010;
        5'd24: c = 6'b110011;
        5'd25: c = 6'b100110;
        5'd26: c = 6'b010110;
        5'd27: c = 6'b110110;
        5'd28: c = 6'b001110;
        5'd29: c = 6'b101110;
        5'd30: c = 6'b011110;
        default: c = 6'b101011;
      endcase
    end
    return c;
  endfunction

  // 3b/4b code (fghj) used when the RD after the 6b block is negative
  function automatic logic [3:0] enc3b4b_neg(input logic [2:0] y, input logic k28,
                                             input logic a7);
    logic [3:0] c;
    c = 4'b0000;
    if (k28) begin
      unique case (y)
        3'd0: c = 4'b1011;
        3'd1: c = 4'b0110;
        3'd2: c = 4'b1010;
        3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;
        3'd5: c = 4'b0101;
        3'd6: c = 4'b1001;
        default: c = 4'b0111;
      endcase
    end else begin
      unique case (y)
        3'd0: c = 4'b1011;
        3'd1: c = 4'b1001;
        3'd2: c = 4'b0101;
        3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;
        3'd5: c = 4'b1010;
        3'd6: c = 4'b0110;
        default: c = a7 ? 4'b0111 : 4'b1110;
      endcase
    end
    return c;
  endfunction

  // Disparity-neutral predicates for each sub-block
  function automatic logic disp_neutral6(input logic [5:0] c);
    return ($countones(c) == 3);
  endfunction

  function automatic logic disp_neutral4(input logic [3:0] c);
    return ($countones(c) == 2);
  endfunction

endpackage

// File: rtl/encoding_multi_8b10b_if.sv
// PIPE-side TX word interface into the multi-lane encoder and its registered outputs.
interface encoding_multi_8b10b_if #(
  parameter int unsigned BYTES = 2
) ();
  import enc8b10b_pkg::*;

  localparam int unsigned DW = BYTE_W * BYTES;
  localparam int unsigned SW = SYM_W * BYTES;

  logic [DW-1:0]    data;
  logic [BYTES-1:0] TXDataK;
  logic             MAC_Data_En;
  logic             TxElecIdle;
  logic             Tx_Compliance;
  logic [SW-1:0]    data_out;
  logic             out_valid;
  logic [BYTES-1:0] K_Err;
  logic             RD_out;

  modport master (
    output data, TXDataK, MAC_Data_En, TxElecIdle, Tx_Compliance,
    input  data_out, out_valid, K_Err, RD_out
  );

  modport slave (
    input  data, TXDataK, MAC_Data_En, TxElecIdle, Tx_Compliance,
    output data_out, out_valid, K_Err, RD_out
  );
endinterface

// File: rtl/enc_8b10b_sym.sv
// Combinational single-symbol 8b/10b encoder with illegal-K substitution.
module enc_8b10b_sym
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data_byte,
  input  logic       k_flag,
  input  logic       rd_in,
  output logic [9:0] code10,
  output logic       rd_next,
  output logic       k_err
);

  logic [7:0] b;
  logic       k28;
  logic       a7;
  logic       rd4;
  logic [5:0] c6_neg;
  logic [5:0] c6;
  logic [3:0] c4_neg;
  logic [3:0] c4;

  // Table lookup, sub-block RD selection and RD propagation
  always_comb begin
    k_err  = k_flag && !is_legal_k(data_byte);
    b      = k_err ? K28_5 : data_byte;
    k28    = k_flag && (b[4:0] == 5'd28);

    c6_neg = enc5b6b_neg(b[4:0], k28);
    // D.07 is neutral but still alternates with RD
    c6     = ((rd_in == RD_POS) && (!disp_neutral6(c6_neg) || (c6_neg == 6'b111000)))
             ? ~c6_neg : c6_neg;
    rd4    = rd_in ^ !disp_neutral6(c6_neg);

    // A7 avoids a run of five equal bits across the sub-block boundary
    a7     = k_flag
             || ((rd4 == RD_NEG) && ((b[4:0] == 5'd17) || (b[4:0] == 5'd18) || (b[4:0] == 5'd20)))
             || ((rd4 == RD_POS) && ((b[4:0] == 5'd11) || (b[4:0] == 5'd13) || (b[4:0] == 5'd14)));

    c4_neg = enc3b4b_neg(b[7:5], k28, a7);
    // x.3 is neutral but alternates; K28 3b codes always alternate
    c4     = ((rd4 == RD_POS) && (k_flag || !disp_neutral4(c4_neg) || (c4_neg == 4'b1100)))
             ? ~c4_neg : c4_neg;
    rd_next = rd4 ^ !disp_neutral4(c4_neg);

    code10 = {c6, c4};
  end

endmodule

// File: rtl/encoding_multi_8b10b.sv
// N-byte-per-clock 8b/10b encoder with lane-chained running disparity.
module encoding_multi_8b10b
  import enc8b10b_pkg::*;
#(
  parameter int unsigned BYTES   = 2,
  parameter logic        RD_INIT = 1'b0
) (
  input  logic                  Bit_Rate_10,
  input  logic                  Rst,
  encoding_multi_8b10b_if.slave bus
);

  localparam int unsigned SW = SYM_W * BYTES;

  logic [BYTES:0]   rd_chain;
  logic [SW-1:0]    code_c;
  logic [BYTES-1:0] kerr_c;

  logic             rd_q;
  logic [SW-1:0]    data_out_q;
  logic             out_valid_q;
  logic [BYTES-1:0] kerr_q;

  // Chain entry: compliance forces negative RD ahead of byte 0
  assign rd_chain[0] = bus.Tx_Compliance ? RD_NEG : rd_q;

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    enc_8b10b_sym u_sym (
      .data_byte (bus.data[BYTE_W*g +: BYTE_W]),
      .k_flag    (bus.TXDataK[g]),
      .rd_in     (rd_chain[g]),
      .code10    (code_c[SYM_W*g +: SYM_W]),
      .rd_next   (rd_chain[g+1]),
      .k_err     (kerr_c[g])
    );
  end

  // Cycle-type priority: idle, then encode, then hold
  always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
    if (!Rst) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      kerr_q      <= '0;
      rd_q        <= RD_INIT;
    end else if (bus.TxElecIdle) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      kerr_q      <= '0;
      rd_q        <= RD_NEG;
    end else if (bus.MAC_Data_En) begin
      data_out_q  <= code_c;
      out_valid_q <= 1'b1;
      kerr_q      <= kerr_c;
      rd_q        <= rd_chain[BYTES];
    end else begin
      out_valid_q <= 1'b0;
      kerr_q      <= '0;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.K_Err     = kerr_q;
  assign bus.RD_out    = rd_q;

endmodule

// File: tb/tb_encoding_multi_8b10b.sv
// Scoreboard bench for the multi-lane 8b/10b encoder at 1, 2 and 4 bytes per clock.
module tb_encoding_multi_8b10b;

  typedef struct {
    logic [39:0] sym;
    logic [3:0]  kerr;
    logic        rd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t q4[$];
  exp_t e1, e2, e4, ep;

  encoding_multi_8b10b_if #(.BYTES(1)) if1 ();
  encoding_multi_8b10b_if #(.BYTES(2)) if2 ();
  encoding_multi_8b10b_if #(.BYTES(4)) if4 ();

  encoding_multi_8b10b #(.BYTES(1), .RD_INIT(1'b0)) dut1 (.Bit_Rate_10(clk), .Rst(rst_n), .bus(if1));
  encoding_multi_8b10b #(.BYTES(2), .RD_INIT(1'b0)) dut2 (.Bit_Rate_10(clk), .Rst(rst_n), .bus(if2));
  encoding_multi_8b10b #(.BYTES(4), .RD_INIT(1'b0)) dut4 (.Bit_Rate_10(clk), .Rst(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic no_exp(input string name);
    total++;
    bad++;
    $display("FAIL %s: got out_valid=1 want no pending word", name);
  endtask

  // Monitors: pop and compare on every presented word
  always @(negedge clk) begin
    if (if1.out_valid === 1'b1) begin
      if (q1.size() == 0) no_exp("b1 extra word");
      else begin
        e1 = q1.pop_front();
        chk("b1 data_out", 64'(if1.data_out), 64'(e1.sym[9:0]));
        chk("b1 K_Err", 64'(if1.K_Err), 64'(e1.kerr[0]));
        chk("b1 RD_out", 64'(if1.RD_out), 64'(e1.rd));
      end
    end
  end

  always @(negedge clk) begin
    if (if2.out_valid === 1'b1) begin
      if (q2.size() == 0) no_exp("b2 extra word");
      else begin
        e2 = q2.pop_front();
        chk("b2 data_out", 64'(if2.data_out), 64'(e2.sym[19:0]));
        chk("b2 K_Err", 64'(if2.K_Err), 64'(e2.kerr[1:0]));
        chk("b2 RD_out", 64'(if2.RD_out), 64'(e2.rd));
      end
    end
  end

  always @(negedge clk) begin
    if (if4.out_valid === 1'b1) begin
      if (q4.size() == 0) no_exp("b4 extra word");
      else begin
        e4 = q4.pop_front();
        chk("b4 data_out", 64'(if4.data_out), 64'(e4.sym));
        chk("b4 K_Err", 64'(if4.K_Err), 64'(e4.kerr));
        chk("b4 RD_out", 64'(if4.RD_out), 64'(e4.rd));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] d, input logic k, input logic [9:0] sym,
                       input logic ke, input logic rd);
    if1.data = d; if1.TXDataK = k; if1.MAC_Data_En = 1'b1;
    ep.sym = 40'(sym); ep.kerr = 4'(ke); ep.rd = rd;
    q1.push_back(ep);
    step();
    if1.MAC_Data_En = 1'b0;
  endtask

  task automatic send2(input logic [15:0] d, input logic [1:0] k, input logic comp,
                       input logic [19:0] sym, input logic [1:0] ke, input logic rd);
    if2.data = d; if2.TXDataK = k; if2.Tx_Compliance = comp; if2.MAC_Data_En = 1'b1;
    ep.sym = 40'(sym); ep.kerr = 4'(ke); ep.rd = rd;
    q2.push_back(ep);
    step();
    if2.MAC_Data_En = 1'b0;
    if2.Tx_Compliance = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d, input logic [3:0] k,
                       input logic [39:0] sym, input logic [3:0] ke, input logic rd);
    if4.data = d; if4.TXDataK = k; if4.MAC_Data_En = 1'b1;
    ep.sym = sym; ep.kerr = ke; ep.rd = rd;
    q4.push_back(ep);
    step();
    if4.MAC_Data_En = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if1.data = '0; if1.TXDataK = '0; if1.MAC_Data_En = 0; if1.TxElecIdle = 0; if1.Tx_Compliance = 0;
    if2.data = '0; if2.TXDataK = '0; if2.MAC_Data_En = 0; if2.TxElecIdle = 0; if2.Tx_Compliance = 0;
    if4.data = '0; if4.TXDataK = '0; if4.MAC_Data_En = 0; if4.TxElecIdle = 0; if4.Tx_Compliance = 0;
    repeat (3) step();
    rst_n = 1'b1;

    chk("b2 reset data_out", 64'(if2.data_out), 64'd0);
    chk("b2 reset out_valid", 64'(if2.out_valid), 64'd0);
    chk("b2 reset K_Err", 64'(if2.K_Err), 64'd0);
    chk("b2 reset RD_out", 64'(if2.RD_out), 64'd0);
    chk("b4 reset RD_out", 64'(if4.RD_out), 64'd0);

    // D0.0 then K28.5 from RD-
    send2(16'hBC00, 2'b10, 1'b0, {10'b0011111010, 10'b1001110100}, 2'b00, 1'b1);
    // K28.5 K28.5 from RD+
    send2(16'hBCBC, 2'b11, 1'b0, {10'b0011111010, 10'b1100000101}, 2'b00, 1'b1);
    // Compliance forces RD- at byte 0
    send2(16'h00BC, 2'b01, 1'b1, {10'b0110001011, 10'b0011111010}, 2'b00, 1'b1);
    // Illegal K 0x00 at RD+ becomes K28.5
    send2(16'h0000, 2'b01, 1'b0, {10'b1001110100, 10'b1100000101}, 2'b01, 1'b0);
    step();
    chk("b2 K_Err one cycle", 64'(if2.K_Err), 64'd0);
    chk("b2 hold out_valid", 64'(if2.out_valid), 64'd0);
    chk("b2 hold data_out", 64'(if2.data_out), 64'({10'b1001110100, 10'b1100000101}));
    // D17.7 (A7 at RD-) then D11.7 (A7 at RD+)
    send2(16'hEBF1, 2'b00, 1'b0, {10'b1101001000, 10'b1000110111}, 2'b00, 1'b0);
    // D7.3 then D3.7 (P7) from RD-
    send2(16'hE367, 2'b00, 1'b0, {10'b1100011110, 10'b1110001100}, 2'b00, 1'b1);
    // D7.3 then K23.7 from RD+
    send2(16'hF767, 2'b10, 1'b0, {10'b0001010111, 10'b0001110011}, 2'b00, 1'b1);

    // Electrical idle beats an enabled word and clears RD
    if2.TxElecIdle = 1'b1; if2.MAC_Data_En = 1'b1; if2.data = 16'hBCBC; if2.TXDataK = 2'b11;
    step();
    chk("b2 idle data_out", 64'(if2.data_out), 64'd0);
    chk("b2 idle out_valid", 64'(if2.out_valid), 64'd0);
    chk("b2 idle RD_out", 64'(if2.RD_out), 64'd0);
    if2.TxElecIdle = 1'b0; if2.MAC_Data_En = 1'b0;
    send2(16'hBCBC, 2'b11, 1'b0, {10'b1100000101, 10'b0011111010}, 2'b00, 1'b0);

    // Reach RD+, then reset mid-word
    send2(16'h00BC, 2'b01, 1'b0, {10'b0110001011, 10'b0011111010}, 2'b00, 1'b1);
    @(negedge clk);
    #1;
    if2.data = 16'hBCBC; if2.TXDataK = 2'b11; if2.MAC_Data_En = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("b2 async rst data_out", 64'(if2.data_out), 64'd0);
    chk("b2 async rst out_valid", 64'(if2.out_valid), 64'd0);
    chk("b2 async rst RD_out", 64'(if2.RD_out), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    if2.MAC_Data_En = 1'b0;
    step();
    send2(16'hBCBC, 2'b11, 1'b0, {10'b1100000101, 10'b0011111010}, 2'b00, 1'b0);

    // Single-byte lane
    send1(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
    send1(8'hBC, 1'b1, 10'b0011111010, 1'b0, 1'b1);
    send1(8'h00, 1'b1, 10'b1100000101, 1'b1, 1'b0);
    step();
    chk("b1 K_Err one cycle", 64'(if1.K_Err), 64'd0);
    chk("b1 hold data_out", 64'(if1.data_out), 64'(10'b1100000101));

    // Four-byte lane
    send4(32'h00BCBC00, 4'b0110,
          {10'b1001110100, 10'b1100000101, 10'b0011111010, 10'b1001110100}, 4'b0000, 1'b0);
    send4(32'hFB0055BC, 4'b1011,
          {10'b1101101000, 10'b1001110100, 10'b1100000101, 10'b0011111010}, 4'b0010, 1'b0);
    step();
    chk("b4 K_Err one cycle", 64'(if4.K_Err), 64'd0);
    chk("b4 hold out_valid", 64'(if4.out_valid), 64'd0);

    repeat (3) step();
    chk("b1 queue drained", 64'(q1.size()), 64'd0);
    chk("b2 queue drained", 64'(q2.size()), 64'd0);
    chk("b4 queue drained", 64'(q4.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoding_multi_8b10b.md
# encoding_multi_8b10b

Parametrised N-byte-per-clock 8b/10b encoder for the TX PHY. It encodes BYTES symbols per clock with the running disparity (RD) chained across byte lanes and carried between words. It adds control-code validation, a compliance RD override and electrical-idle blanking. It sits between the PIPE TX data interface and the serializer, and replaces the single-byte encode + RD FSM pair for 16/32-bit PIPE widths.

## Interface
- BYTES, 2: symbols per clock. Legal values are 1, 2 and 4.
- RD_INIT, 0: RD after reset. 0 = negative, 1 = positive.
- Bit_Rate_10  in  1: symbol-word clock (bit rate / (10·BYTES)).
- Rst  in  1: asynchronous, active-low reset.
- data  in  8·BYTES: byte k is data[8k+7:8k]; byte 0 is transmitted first.
- TXDataK  in  BYTES: bit k=1 marks byte k as a control (K) symbol.
- MAC_Data_En  in  1: the word on data/TXDataK is valid this cycle.
- TxElecIdle  in  1: electrical idle request. Overrides MAC_Data_En.
- Tx_Compliance  in  1: forces negative RD before byte 0 of this word.
- data_out  out  10·BYTES: symbol k is data_out[10k+9:10k], bit order {a,b,c,d,e,i,f,g,h,j} with MSB = a.
- out_valid  out  1: data_out holds a newly encoded word.
- K_Err  out  BYTES: bit k pulses when control byte k was not a legal K code.
- RD_out  out  1: RD after the last symbol of the registered word. 1 = positive.

## Operation
- RD chain, within one word:
  - rd[0] = Tx_Compliance ? negative : RD register.
  - Symbol k uses rd[k] to select the RD- or RD+ code.
  - rd[k+1] = rd[k] XOR (symbol k is disparity-non-neutral).
  - The RD register loads rd[BYTES] only on an encoded cycle.
- Data symbols follow standard 5b/6b and 3b/4b tables, including:
  - the D.x.7 alternate (A7) selection;
  - the D.07 / x.3 sub-block disparity rules.
- Legal K codes: K28.0–K28.7 (0x1C,0x3C,0x5C,0x7C,0x9C,0xBC,0xDC,0xFC), K23.7 (0xF7), K27.7 (0xFB), K29.7 (0xFD), K30.7 (0xFE).
- Illegal K byte:
  - the symbol is replaced by K28.5 at the current rd[k];
  - the RD chain continues from that K28.5;
  - K_Err[k]=1 for the cycle in which the word appears on data_out.
- TXDataK bits are ignored for bytes whose data is not a legal K code only through this substitution. No other error path exists.
- Cycle types, by priority:
  1. TxElecIdle=1: data_out <= 0, out_valid <= 0, K_Err <= 0. RD register resets to negative.
  2. MAC_Data_En=1: encode, register data_out, out_valid <= 1, update RD.
  3. Otherwise: data_out holds its previous value, out_valid <= 0, K_Err <= 0, RD unchanged.
- Tx_Compliance is sampled only on an encoded cycle. It has no effect otherwise.
- With BYTES=1 the block is functionally identical to single-byte encode plus RD tracking, with an added register stage.

## Timing
- Latency: 1 clock. Inputs sampled on rising edge n appear on data_out/out_valid/K_Err/RD_out after edge n.
- No back-pressure and no ready signal. Every enabled word is encoded.
- Reset (Rst=0, asynchronous, takes effect immediately):
  - data_out=0, out_valid=0, K_Err=0;
  - RD register=RD_INIT, RD_out=RD_INIT.
- Reset deassertion mid-stream: the first encoded word after release uses RD_INIT, unless Tx_Compliance=1.
- TxElecIdle and MAC_Data_En both high: idle wins and the word is dropped.
- Back-to-back enabled words: RD is continuous across the word boundary. Symbol 0 of word n+1 uses the RD_out of word n.
- Critical path: BYTES serial RD steps through the table lookups. BYTES=4 must close at the 32-bit PIPE rate.

## Structure
- Package enc8b10b_pkg holds:
  - RD encoding constants (RD_NEG=0, RD_POS=1);
  - the legal K-code byte constants;
  - 5b/6b and 3b/4b table functions returning the RD- code;
  - the disparity-neutral predicate.
- Sub-module enc_8b10b_sym: combinational single-symbol encoder.
  - Inputs: byte, k flag, rd_in.
  - Outputs: code10, rd_next, k_err.
  - Instantiated BYTES times in a generate chain.
- The top level contains only the rd chain wiring, the cycle-type priority mux and the output registers.

## Test plan
- BYTES=2, reset, then data=0xBC00, TXDataK=2'b10, enable:
  - sym0 D0.0 RD- = 1001110100 (neutral);
  - sym1 K28.5 RD- = 0011111010;
  - RD_out=1, out_valid=1 one cycle later.
- Next cycle data=0xBCBC, TXDataK=2'b11:
  - sym0 = 1100000101 (RD+);
  - sym1 = 0011111010;
  - RD_out=1.
- Tx_Compliance=1 while RD=+, data=0x00BC, K=2'b01:
  - sym0 = 0011111010 (forced RD-);
  - sym1 = D0.0 RD+ = 0110001011;
  - RD_out=1.
- Illegal K 0x00 with K=2'b01:
  - sym0 = K28.5 code for the current RD;
  - K_Err=2'b01 for exactly one cycle.
- TxElecIdle=1 with MAC_Data_En=1:
  - data_out=0, out_valid=0;
  - next encoded K28.5 uses RD- (0011111010).
- Assert Rst low mid-word with RD=+:
  - outputs clear immediately;
  - after release, K28.5 encodes 0011111010 (RD_INIT=0).
- Repeat the first and fourth scenarios with BYTES=1 and BYTES=4.
